// File: rtl/riscv_biu_arbiter_pkg.sv
// Shared types for the BIU arbiter slice: bus access sizes, arbitration
// source IDs and arbiter FSM states.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

endpackage

package riscv_arb_pkg;

  typedef enum logic {
    ARB_SRC_IMEM = 1'b0,
    ARB_SRC_DMEM = 1'b1
  } arb_src_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_DLOCK = 1'b1
  } arb_state_t;

  // The source that is not s; used to hand priority across when both request.
  function automatic arb_src_t arb_other(input arb_src_t s);
    return (s == ARB_SRC_IMEM) ? ARB_SRC_DMEM : ARB_SRC_IMEM;
  endfunction

endpackage

// File: rtl/riscv_biu_arbiter_if.sv
// Bundle of the fetch port, data port and downstream memory bus seen by the
// arbiter. The slave modport is the arbiter's view; master is the view of
// the surrounding core and memory.
interface riscv_biu_arbiter_if
  import biu_constants_pkg::*;
#(
  parameter int XLEN = 32
);

  // fetch port
  logic            imem_req_i;
  logic [XLEN-1:0] imem_adr_i;
  logic            imem_gnt_o;
  logic [XLEN-1:0] imem_q_o;
  logic            imem_ack_o;
  logic            imem_err_o;

  // data port
  logic            dmem_req_i;
  logic [XLEN-1:0] dmem_adr_i;
  logic [XLEN-1:0] dmem_d_i;
  logic            dmem_we_i;
  biu_size_t       dmem_size_i;
  logic            dmem_lock_i;
  logic            dmem_gnt_o;
  logic [XLEN-1:0] dmem_q_o;
  logic            dmem_ack_o;
  logic            dmem_err_o;

  // downstream bus
  logic            mem_req_o;
  logic [XLEN-1:0] mem_adr_o;
  logic [XLEN-1:0] mem_d_o;
  logic            mem_we_o;
  biu_size_t       mem_size_o;
  logic            mem_gnt_i;
  logic [XLEN-1:0] mem_q_i;
  logic            mem_ack_i;
  logic            mem_err_i;

  // status
  logic            arb_proterr_o;

  modport slave (
    input  imem_req_i, imem_adr_i,
    output imem_gnt_o, imem_q_o, imem_ack_o, imem_err_o,
    input  dmem_req_i, dmem_adr_i, dmem_d_i, dmem_we_i, dmem_size_i, dmem_lock_i,
    output dmem_gnt_o, dmem_q_o, dmem_ack_o, dmem_err_o,
    output mem_req_o, mem_adr_o, mem_d_o, mem_we_o, mem_size_o,
    input  mem_gnt_i, mem_q_i, mem_ack_i, mem_err_i,
    output arb_proterr_o
  );

  modport master (
    output imem_req_i, imem_adr_i,
    input  imem_gnt_o, imem_q_o, imem_ack_o, imem_err_o,
    output dmem_req_i, dmem_adr_i, dmem_d_i, dmem_we_i, dmem_size_i, dmem_lock_i,
    input  dmem_gnt_o, dmem_q_o, dmem_ack_o, dmem_err_o,
    input  mem_req_o, mem_adr_o, mem_d_o, mem_we_o, mem_size_o,
    output mem_gnt_i, mem_q_i, mem_ack_i, mem_err_i,
    input  arb_proterr_o
  );

endinterface

// File: rtl/riscv_biu_arbiter_idfifo.sv
// riscv_arb_idfifo: in-order queue of source IDs for outstanding downstream
// transactions. A push and a pop in the same cycle both take effect, so a
// full queue can accept a push while its head is being retired.
module riscv_arb_idfifo
  import riscv_arb_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  arb_src_t                 din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output arb_src_t                 head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_src_t         slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Power-of-two depth lets the pointer wrap on overflow; a single slot never moves.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) return '0;
    return p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = slots[rd_ptr];
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // ID storage: data only, no reset needed since count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) slots[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter: shares one downstream memory bus between the fetch and
// data ports. One requester is selected per cycle; the source of every
// accepted request is queued so in-order responses return to their issuer
// in the same cycle they arrive.
// Build option: RV12_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the data port always wins over the fetch port.
module riscv_biu_arbiter
  import riscv_arb_pkg::*;
  import biu_constants_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
)(
  input  logic                clk_i,
  input  logic                rst_ni,
  riscv_biu_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_t       state;
  arb_src_t         sel;
  arb_src_t         fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             sel_req;
  logic             resp;
  logic             resp_vld;
  logic             issue;
  logic             push;
  logic             drains;
  logic             proterr_q;

`ifdef RV12_ARB_ROUND_ROBIN_EN
  arb_src_t         last_src;

  // Remember who was granted last so the other source wins the next tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   last_src <= ARB_SRC_IMEM;
    else if (push) last_src <= sel;
  end
`endif

  // Pick the requester for this cycle; a locked data sequence owns the bus.
  always_comb begin
    sel = ARB_SRC_IMEM;
    if (state == ARB_DLOCK) begin
      sel = ARB_SRC_DMEM;
    end
`ifdef RV12_ARB_ROUND_ROBIN_EN
    else if (bus.dmem_req_i && bus.imem_req_i) begin
      sel = arb_other(last_src);
    end
`endif
    else if (bus.dmem_req_i) begin
      sel = ARB_SRC_DMEM;
    end
  end

  // A response retiring the head frees a slot for a request in the same cycle.
  assign sel_req  = (sel == ARB_SRC_DMEM) ? bus.dmem_req_i : bus.imem_req_i;
  assign resp     = bus.mem_ack_i | bus.mem_err_i;
  assign resp_vld = rst_ni & resp & ~fifo_empty;
  assign issue    = rst_ni & sel_req & (~fifo_full | resp_vld);
  assign push     = issue & bus.mem_gnt_i;
  assign drains   = (fifo_count == CNT_W'(resp_vld)) & ~push;

  riscv_arb_idfifo #(
    .DEPTH (DEPTH)
  ) u_idfifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .din    (sel),
    .pop    (resp_vld),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head),
    .count  (fifo_count)
  );

  // Forward the selected request downstream and route responses to the head's port.
  always_comb begin
    bus.mem_req_o  = issue;
    bus.mem_adr_o  = '0;
    bus.mem_d_o    = '0;
    bus.mem_we_o   = 1'b0;
    bus.mem_size_o = WORD;
    if (issue) begin
      if (sel == ARB_SRC_DMEM) begin
        bus.mem_adr_o  = bus.dmem_adr_i;
        bus.mem_d_o    = bus.dmem_d_i;
        bus.mem_we_o   = bus.dmem_we_i;
        bus.mem_size_o = bus.dmem_size_i;
      end else begin
        bus.mem_adr_o  = bus.imem_adr_i;
      end
    end

    bus.imem_gnt_o = push & (sel == ARB_SRC_IMEM);
    bus.dmem_gnt_o = push & (sel == ARB_SRC_DMEM);

    bus.imem_ack_o = 1'b0;
    bus.imem_err_o = 1'b0;
    bus.imem_q_o   = '0;
    bus.dmem_ack_o = 1'b0;
    bus.dmem_err_o = 1'b0;
    bus.dmem_q_o   = '0;
    if (resp_vld) begin
      if (fifo_head == ARB_SRC_IMEM) begin
        bus.imem_ack_o = bus.mem_ack_i;
        bus.imem_err_o = bus.mem_err_i;
        bus.imem_q_o   = bus.mem_q_i;
      end else begin
        bus.dmem_ack_o = bus.mem_ack_i;
        bus.dmem_err_o = bus.mem_err_i;
        bus.dmem_q_o   = bus.mem_q_i;
      end
    end
  end

  // Lock FSM: enter on a locked data grant, leave once unlocked and drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (push && (sel == ARB_SRC_DMEM) && bus.dmem_lock_i) state <= ARB_DLOCK;
        end
        ARB_DLOCK: begin
          if (!bus.dmem_lock_i && drains) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 proterr_q <= 1'b0;
    else if (resp && fifo_empty) proterr_q <= 1'b1;
  end

  assign bus.arb_proterr_o = proterr_q;

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Directed testbench for riscv_biu_arbiter (XLEN=32, DEPTH=2).
module tb_riscv_biu_arbiter;
  import biu_constants_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic exp_d [4];

  riscv_biu_arbiter_if #(.XLEN(32)) bus ();

  riscv_biu_arbiter #(
    .XLEN  (32),
    .DEPTH (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    bus.imem_req_i  = 1'b0;
    bus.imem_adr_i  = '0;
    bus.dmem_req_i  = 1'b0;
    bus.dmem_adr_i  = '0;
    bus.dmem_d_i    = '0;
    bus.dmem_we_i   = 1'b0;
    bus.dmem_size_i = WORD;
    bus.dmem_lock_i = 1'b0;
    bus.mem_gnt_i   = 1'b0;
    bus.mem_q_i     = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_err_i   = 1'b0;

    // reset state
    tick;
    check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    check("rst_mem_size", 32'(bus.mem_size_o), 32'(WORD));
    check("rst_proterr", 32'(bus.arb_proterr_o), 32'd0);
    check("rst_imem_gnt", 32'(bus.imem_gnt_o), 32'd0);
    #1 rst_n = 1'b1;
    tick;

    // 1: single fetch, response the next cycle
    bus.imem_req_i = 1'b1; bus.imem_adr_i = 32'h200; bus.mem_gnt_i = 1'b1;
    settle;
    check("t1_mem_req", 32'(bus.mem_req_o), 32'd1);
    check("t1_mem_adr", bus.mem_adr_o, 32'h200);
    check("t1_mem_size", 32'(bus.mem_size_o), 32'(WORD));
    check("t1_imem_gnt", 32'(bus.imem_gnt_o), 32'd1);
    check("t1_dmem_gnt", 32'(bus.dmem_gnt_o), 32'd0);
    tick;
    bus.imem_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_q_i = 32'h13;
    settle;
    check("t1_imem_gnt_off", 32'(bus.imem_gnt_o), 32'd0);
    check("t1_imem_ack", 32'(bus.imem_ack_o), 32'd1);
    check("t1_imem_q", bus.imem_q_o, 32'h13);
    check("t1_dmem_ack", 32'(bus.dmem_ack_o), 32'd0);
    tick;
    bus.mem_ack_i = 1'b0;
    settle;
    check("t1_imem_ack_off", 32'(bus.imem_ack_o), 32'd0);
    tick;

    // 2: simultaneous requests, data port (a byte write) first
    bus.imem_req_i = 1'b1; bus.imem_adr_i = 32'h204;
    bus.dmem_req_i = 1'b1; bus.dmem_adr_i = 32'h300; bus.dmem_d_i = 32'h55;
    bus.dmem_we_i = 1'b1; bus.dmem_size_i = BYTE;
    settle;
    check("t2_dmem_gnt", 32'(bus.dmem_gnt_o), 32'd1);
    check("t2_imem_gnt", 32'(bus.imem_gnt_o), 32'd0);
    check("t2_mem_adr", bus.mem_adr_o, 32'h300);
    check("t2_mem_d", bus.mem_d_o, 32'h55);
    check("t2_mem_we", 32'(bus.mem_we_o), 32'd1);
    check("t2_mem_size", 32'(bus.mem_size_o), 32'(BYTE));
    tick;
    bus.dmem_req_i = 1'b0; bus.dmem_we_i = 1'b0; bus.dmem_size_i = WORD;
    settle;
    check("t2_imem_gnt2", 32'(bus.imem_gnt_o), 32'd1);
    check("t2_mem_adr2", bus.mem_adr_o, 32'h204);
    check("t2_mem_we2", 32'(bus.mem_we_o), 32'd0);
    tick;
    bus.imem_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_q_i = 32'hAAAA;
    settle;
    check("t2_dmem_ack", 32'(bus.dmem_ack_o), 32'd1);
    check("t2_dmem_q", bus.dmem_q_o, 32'hAAAA);
    check("t2_imem_ack_first", 32'(bus.imem_ack_o), 32'd0);
    tick;
    bus.mem_q_i = 32'hBBBB;
    settle;
    check("t2_imem_ack", 32'(bus.imem_ack_o), 32'd1);
    check("t2_imem_q", bus.imem_q_o, 32'hBBBB);
    check("t2_dmem_ack_second", 32'(bus.dmem_ack_o), 32'd0);
    tick;
    bus.mem_ack_i = 1'b0;

    // 3: continuous requests from both ports with one response per cycle
`ifdef RV12_ARB_ROUND_ROBIN_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
    for (int k = 0; k < 4; k++) begin
      bus.imem_req_i = 1'b1; bus.imem_adr_i = 32'h600 + 32'(k);
      bus.dmem_req_i = 1'b1; bus.dmem_adr_i = 32'h700 + 32'(k);
      bus.mem_ack_i = (k > 0); bus.mem_q_i = 32'h100 + 32'(k);
      settle;
      check($sformatf("t3_dmem_gnt%0d", k), 32'(bus.dmem_gnt_o), 32'(exp_d[k]));
      check($sformatf("t3_imem_gnt%0d", k), 32'(bus.imem_gnt_o), 32'(!exp_d[k]));
      if (k > 0) begin
        check($sformatf("t3_dmem_ack%0d", k), 32'(bus.dmem_ack_o), 32'(exp_d[k-1]));
        check($sformatf("t3_imem_ack%0d", k), 32'(bus.imem_ack_o), 32'(!exp_d[k-1]));
      end
      tick;
    end
    bus.imem_req_i = 1'b0; bus.dmem_req_i = 1'b0; bus.mem_ack_i = 1'b1;
    settle;
    check("t3_drain_dmem_ack", 32'(bus.dmem_ack_o), 32'(exp_d[3]));
    check("t3_drain_imem_ack", 32'(bus.imem_ack_o), 32'(!exp_d[3]));
    tick;
    bus.mem_ack_i = 1'b0;

    // 4: outstanding limit of two, push through a full queue on a response
    bus.imem_req_i = 1'b1; bus.imem_adr_i = 32'h400; bus.mem_gnt_i = 1'b0;
    settle;
    check("t4_req_no_gnt", 32'(bus.mem_req_o), 32'd1);
    check("t4_imem_gnt_blocked", 32'(bus.imem_gnt_o), 32'd0);
    tick;
    bus.mem_gnt_i = 1'b1;
    settle;
    check("t4_gnt_a", 32'(bus.imem_gnt_o), 32'd1);
    tick;
    settle;
    check("t4_gnt_b", 32'(bus.imem_gnt_o), 32'd1);
    tick;
    settle;
    check("t4_full_req", 32'(bus.mem_req_o), 32'd0);
    check("t4_full_gnt", 32'(bus.imem_gnt_o), 32'd0);
    tick;
    bus.mem_ack_i = 1'b1; bus.mem_q_i = 32'h11;
    settle;
    check("t4_pop_push_req", 32'(bus.mem_req_o), 32'd1);
    check("t4_pop_push_gnt", 32'(bus.imem_gnt_o), 32'd1);
    check("t4_pop_push_ack", 32'(bus.imem_ack_o), 32'd1);
    check("t4_pop_push_q", bus.imem_q_o, 32'h11);
    tick;
    bus.mem_ack_i = 1'b0;
    settle;
    check("t4_still_full", 32'(bus.mem_req_o), 32'd0);
    tick;
    bus.imem_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_q_i = 32'h22;
    settle;
    check("t4_drain1_ack", 32'(bus.imem_ack_o), 32'd1);
    check("t4_drain1_q", bus.imem_q_o, 32'h22);
    tick;
    bus.mem_ack_i = 1'b0; bus.mem_err_i = 1'b1; bus.mem_q_i = 32'h33;
    settle;
    check("t4_drain2_err", 32'(bus.imem_err_o), 32'd1);
    check("t4_drain2_ack", 32'(bus.imem_ack_o), 32'd0);
    check("t4_drain2_dmem_err", 32'(bus.dmem_err_o), 32'd0);
    tick;
    bus.mem_err_i = 1'b0;

    // 5: locked data write holds off the fetch port
    bus.dmem_req_i = 1'b1; bus.dmem_adr_i = 32'h1000; bus.dmem_d_i = 32'hCAFE;
    bus.dmem_we_i = 1'b1; bus.dmem_lock_i = 1'b1;
    bus.imem_req_i = 1'b1; bus.imem_adr_i = 32'h208;
    settle;
    check("t5_dmem_gnt", 32'(bus.dmem_gnt_o), 32'd1);
    check("t5_mem_adr", bus.mem_adr_o, 32'h1000);
    check("t5_mem_d", bus.mem_d_o, 32'hCAFE);
    check("t5_mem_we", 32'(bus.mem_we_o), 32'd1);
    tick;
    bus.dmem_req_i = 1'b0; bus.dmem_we_i = 1'b0;
    settle;
    check("t5_locked_req", 32'(bus.mem_req_o), 32'd0);
    check("t5_locked_imem_gnt", 32'(bus.imem_gnt_o), 32'd0);
    tick;
    bus.mem_ack_i = 1'b1;
    settle;
    check("t5_dmem_ack", 32'(bus.dmem_ack_o), 32'd1);
    check("t5_locked_imem_gnt2", 32'(bus.imem_gnt_o), 32'd0);
    tick;
    bus.mem_ack_i = 1'b0; bus.dmem_lock_i = 1'b0;
    settle;
    check("t5_unlocking_imem_gnt", 32'(bus.imem_gnt_o), 32'd0);
    tick;
    settle;
    check("t5_released_imem_gnt", 32'(bus.imem_gnt_o), 32'd1);
    check("t5_released_adr", bus.mem_adr_o, 32'h208);
    tick;
    bus.imem_req_i = 1'b0; bus.mem_ack_i = 1'b1;
    settle;
    check("t5_imem_ack", 32'(bus.imem_ack_o), 32'd1);
    tick;

    // 6: stray response, then reset in the middle of a read
    settle;
    check("t6_stray_imem_ack", 32'(bus.imem_ack_o), 32'd0);
    check("t6_stray_dmem_ack", 32'(bus.dmem_ack_o), 32'd0);
    tick;
    bus.mem_ack_i = 1'b0;
    settle;
    check("t6_proterr_set", 32'(bus.arb_proterr_o), 32'd1);
    tick;
    bus.imem_req_i = 1'b1; bus.imem_adr_i = 32'h500;
    settle;
    check("t6_read_gnt", 32'(bus.imem_gnt_o), 32'd1);
    tick;
    bus.mem_q_i = 32'hDEAD;
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    check("t6_rst_mem_adr", bus.mem_adr_o, 32'd0);
    check("t6_rst_imem_gnt", 32'(bus.imem_gnt_o), 32'd0);
    check("t6_rst_proterr", 32'(bus.arb_proterr_o), 32'd0);
    check("t6_rst_mem_size", 32'(bus.mem_size_o), 32'(WORD));
    bus.mem_ack_i = 1'b1;
    #1;
    check("t6_rst_imem_ack", 32'(bus.imem_ack_o), 32'd0);
    check("t6_rst_imem_q", bus.imem_q_o, 32'd0);
    tick;
    #1 rst_n = 1'b1; bus.imem_req_i = 1'b0;
    #1;
    check("t6_late_imem_ack", 32'(bus.imem_ack_o), 32'd0);
    tick;
    bus.mem_ack_i = 1'b0;
    settle;
    check("t6_late_proterr", 32'(bus.arb_proterr_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
